// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 scan-code sequencer: pops the keyboard FIFO one byte per three
// cycles, decodes E0/F0 prefixes and tracks the held key, presses and overflow.
module ps2_kbd_ctrl #(
  parameter int PRESS_W = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ready_i,
  input  logic [7:0]         data_i,
  input  logic               overflow_i,
  input  logic               ovf_clr_i,
  output logic               nextdata_n_o,
  output logic [7:0]         key_code_o,
  output logic               key_ext_o,
  output logic               key_valid_o,
  output logic [PRESS_W-1:0] press_cnt_o,
  output logic               make_pulse_o,
  output logic               break_pulse_o,
  output logic               ovf_sticky_o
);

  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, POP, RECOV} state_e;

  state_e             state_q;
  logic               nextdata_n_q;
  logic [7:0]         key_code_q;
  logic               key_ext_q;
  logic               key_valid_q;
  logic [PRESS_W-1:0] press_cnt_q;
  logic               make_q;
  logic               break_q;
  logic               ovf_q;
  logic               ext_pend_q;
  logic               brk_pend_q;
  logic [TW-1:0]      tmo_q;

  logic               same_key;
  logic               pending;
  logic [TW-1:0]      tmo_d;
  logic [PRESS_W-1:0] press_cnt_d;

  // A byte naming the held key with the same extension is a repeat (make) or its release (break)
  assign same_key    = key_valid_q && (data_i == key_code_q) && (ext_pend_q == key_ext_q);
  assign pending     = ext_pend_q | brk_pend_q;
  assign tmo_d       = tmo_q + 1'b1;
  assign press_cnt_d = press_cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      nextdata_n_q <= 1'b1;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_valid_q  <= 1'b0;
      press_cnt_q  <= '0;
      make_q       <= 1'b0;
      break_q      <= 1'b0;
      ovf_q        <= 1'b0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      tmo_q        <= '0;
    end else begin
      make_q  <= 1'b0;
      break_q <= 1'b0;

      if (overflow_i) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (ready_i) begin
            state_q      <= POP;
            nextdata_n_q <= 1'b0;
            if (data_i == 8'hE0) begin
              ext_pend_q <= 1'b1;
            end else if (data_i == 8'hF0) begin
              brk_pend_q <= 1'b1;
            end else if (data_i != 8'hE1) begin
              ext_pend_q <= 1'b0;
              brk_pend_q <= 1'b0;
              if (brk_pend_q) begin
                if (same_key) begin
                  key_valid_q <= 1'b0;
                  break_q     <= 1'b1;
                end
              end else if (!same_key) begin
                key_code_q  <= data_i;
                key_ext_q   <= ext_pend_q;
                key_valid_q <= 1'b1;
                press_cnt_q <= press_cnt_d;
                make_q      <= 1'b1;
              end
            end
          end
        end
        POP: begin
          state_q      <= RECOV;
          nextdata_n_q <= 1'b1;
        end
        RECOV:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // A prefix left dangling while the FIFO stays empty is dropped after TIMEOUT idle cycles
      if ((state_q == IDLE) && !ready_i && pending) begin
        if (tmo_q == TO_LAST) begin
          tmo_q      <= '0;
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end else begin
          tmo_q <= tmo_d;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign nextdata_n_o  = nextdata_n_q;
  assign key_code_o    = key_code_q;
  assign key_ext_o     = key_ext_q;
  assign key_valid_o   = key_valid_q;
  assign press_cnt_o   = press_cnt_q;
  assign make_pulse_o  = make_q;
  assign break_pulse_o = break_q;
  assign ovf_sticky_o  = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: a queue-based FIFO feeds the DUT and a
// cycle-indexed behavioural model predicts every output on every cycle.
module tb_ps2_kbd_ctrl;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rstI = 1'b1;
  logic       readyI = 1'b0;
  logic [7:0] dataI = 8'h00;
  logic       overflowI = 1'b0;
  logic       ovfClrI = 1'b0;

  logic       nextdata_n_o;
  logic [7:0] key_code_o;
  logic       key_ext_o;
  logic       key_valid_o;
  logic [7:0] press_cnt_o;
  logic       make_pulse_o;
  logic       break_pulse_o;
  logic       ovf_sticky_o;

  ps2_kbd_ctrl #(.PRESS_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk_i         (clk),
    .rst_i         (rstI),
    .ready_i       (readyI),
    .data_i        (dataI),
    .overflow_i    (overflowI),
    .ovf_clr_i     (ovfClrI),
    .nextdata_n_o  (nextdata_n_o),
    .key_code_o    (key_code_o),
    .key_ext_o     (key_ext_o),
    .key_valid_o   (key_valid_o),
    .press_cnt_o   (press_cnt_o),
    .make_pulse_o  (make_pulse_o),
    .break_pulse_o (break_pulse_o),
    .ovf_sticky_o  (ovf_sticky_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Model state: cycle index, key bookkeeping and the cycle of the next allowed acceptance
  int         cyc = 0;
  bit         modelLive = 0;
  int         nextAllowed = 0;
  int         popCycle = -1;
  int         idleRun = 0;
  bit         pendExt = 0, pendBrk = 0;
  bit         mNext = 1, mExt = 0, mValid = 0, mMake = 0, mBreak = 0, mOvf = 0;
  logic [7:0] mCode = 8'h00;
  int         mCnt = 0;

  always @(posedge clk) begin
    mMake  = 0;
    mBreak = 0;
    if (rstI) begin
      mCode = 8'h00; mExt = 0; mValid = 0; mCnt = 0; mOvf = 0;
      pendExt = 0; pendBrk = 0; idleRun = 0;
      nextAllowed = cyc + 1;
      popCycle = -1;
      modelLive = 1;
    end else begin
      if (overflowI) mOvf = 1;
      else if (ovfClrI) mOvf = 0;
      if (readyI && cyc >= nextAllowed) begin
        nextAllowed = cyc + 3;
        popCycle = cyc + 1;
        idleRun = 0;
        if (dataI == 8'hE0) pendExt = 1;
        else if (dataI == 8'hF0) pendBrk = 1;
        else if (dataI != 8'hE1) begin
          if (pendBrk) begin
            if (mValid && mCode == dataI && mExt == pendExt) begin
              mValid = 0;
              mBreak = 1;
            end
          end else if (!(mValid && mCode == dataI && mExt == pendExt)) begin
            mCode = dataI; mExt = pendExt; mValid = 1;
            mCnt = (mCnt + 1) % 256;
            mMake = 1;
          end
          pendExt = 0;
          pendBrk = 0;
        end
      end else if (cyc >= nextAllowed && (pendExt || pendBrk)) begin
        idleRun++;
        if (idleRun == TIMEOUT) begin
          pendExt = 0; pendBrk = 0; idleRun = 0;
        end
      end else begin
        idleRun = 0;
      end
    end
    mNext = (cyc + 1 != popCycle);
    cyc++;
  end

  function automatic logic [31:0] dutVec();
    return {10'd0, nextdata_n_o, key_code_o, key_ext_o, key_valid_o, press_cnt_o,
            make_pulse_o, break_pulse_o, ovf_sticky_o};
  endfunction

  always @(negedge clk) begin
    if (modelLive)
      checkOutput("outputs", dutVec(),
                  {10'd0, mNext, mCode, mExt, mValid, mCnt[7:0], mMake, mBreak, mOvf});
  end

  // FIFO feeder and event monitor
  logic [7:0] fifo[$];
  int popLog[$];
  int popCount = 0, makeCount = 0, breakCount = 0;
  int makeCyc = 0, readyCyc = 0;

  always @(negedge clk) begin
    if (modelLive) begin
      if (nextdata_n_o === 1'b0) begin
        popCount++;
        popLog.push_back(cyc);
        if (fifo.size() > 0) fifo.delete(0);
      end
      if (make_pulse_o === 1'b1) begin makeCount++; makeCyc = cyc; end
      if (break_pulse_o === 1'b1) breakCount++;
    end
    if (!readyI && fifo.size() > 0) readyCyc = cyc;
    readyI = (fifo.size() > 0);
    dataI  = readyI ? fifo[0] : 8'h00;
  end

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitDrain(input int bound);
    int k = 0;
    do begin @(posedge clk); #1; k++; end while (fifo.size() > 0 && k < bound);
    if (fifo.size() > 0) begin
      checkOutput("drain_timeout", fifo.size(), 0);
      fifo.delete();
    end
    waitCycles(1);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo.push_back(b);
    waitDrain(20);
  endtask

  initial begin
    int p0, b0, m0, idx0;
    rstI = 1;
    repeat (3) @(posedge clk);
    #1 rstI = 0;
    checkOutput("reset_state", dutVec(), 32'h0020_0000);

    p0 = popCount;
    applyStimulus(8'h1C);
    checkOutput("make_latency", makeCyc - readyCyc, 1);
    checkOutput("single_pop", popCount - p0, 1);
    checkOutput("first_code", key_code_o, 8'h1C);
    checkOutput("first_valid", key_valid_o, 1);
    checkOutput("first_cnt", press_cnt_o, 8'd1);

    b0 = breakCount;
    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    checkOutput("typematic_cnt", press_cnt_o, 8'd1);
    checkOutput("break_once", breakCount - b0, 1);
    checkOutput("released_valid", key_valid_o, 0);
    checkOutput("retained_code", key_code_o, 8'h1C);

    b0 = breakCount;
    applyStimulus(8'hE0); applyStimulus(8'h75);
    applyStimulus(8'hF0); applyStimulus(8'h75);
    checkOutput("ext_mismatch_valid", key_valid_o, 1);
    checkOutput("ext_mismatch_ext", key_ext_o, 1);
    checkOutput("ext_mismatch_nobreak", breakCount - b0, 0);
    checkOutput("ext_cnt", press_cnt_o, 8'd2);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    checkOutput("ext_break", breakCount - b0, 1);
    checkOutput("ext_released", key_valid_o, 0);

    applyStimulus(8'hF0);
    waitCycles(20);
    applyStimulus(8'h32);
    checkOutput("timeout_make_code", key_code_o, 8'h32);
    checkOutput("timeout_make_cnt", press_cnt_o, 8'd3);
    b0 = breakCount;
    applyStimulus(8'hF0);
    waitCycles(10);
    applyStimulus(8'h32);
    checkOutput("short_gap_break", breakCount - b0, 1);
    checkOutput("short_gap_valid", key_valid_o, 0);
    checkOutput("short_gap_cnt", press_cnt_o, 8'd3);

    overflowI = 1; waitCycles(1); overflowI = 0;
    checkOutput("ovf_set", ovf_sticky_o, 1);
    overflowI = 1; ovfClrI = 1; waitCycles(1); overflowI = 0; ovfClrI = 0;
    checkOutput("ovf_set_wins", ovf_sticky_o, 1);
    ovfClrI = 1; waitCycles(1); ovfClrI = 0;
    checkOutput("ovf_clear", ovf_sticky_o, 0);

    applyStimulus(8'h1C);
    overflowI = 1; waitCycles(1); overflowI = 0;
    fifo.push_back(8'h5A);
    waitCycles(1);
    checkOutput("in_pop", nextdata_n_o, 0);
    rstI = 1; waitCycles(1); rstI = 0;
    checkOutput("reset_mid_pop", dutVec(), 32'h0020_0000);
    waitCycles(2);

    m0 = makeCount; b0 = breakCount; idx0 = popLog.size();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = 8'h01 + 8'(i % 127);
      fifo.push_back(c); fifo.push_back(8'hF0); fifo.push_back(c);
    end
    waitDrain(3000);
    waitCycles(3);
    checkOutput("wrap_cnt", press_cnt_o, 8'd0);
    checkOutput("wrap_makes", makeCount - m0, 256);
    checkOutput("wrap_breaks", breakCount - b0, 256);
    checkOutput("wrap_pops", popLog.size() - idx0, 768);
    if (popLog.size() - idx0 == 768)
      checkOutput("stream_spacing", popLog[popLog.size() - 1] - popLog[idx0], 767 * 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Sequencer sitting between the ps2_keyboard receive FIFO and the display/consumer logic.
- Watches `ready`, pops each scan-code byte through a one-cycle `nextdata_n` pulse, and decodes PS/2 set-2 prefixes (E0 extended, F0 break).
- Maintains the currently held key, a press counter that ignores typematic repeats, and a sticky FIFO-overflow flag.
- Outputs feed the bcd7seg pair directly.

Parameters:
- `PRESS_W`, default 8: width of the press counter; the counter wraps modulo 2^PRESS_W.
- `TIMEOUT`, default 1000000: idle cycles after which a dangling prefix (E0/F0 with no following code) is discarded.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `ready`  input  1  FIFO non-empty, from ps2_keyboard.
- `data`  input  8  FIFO head byte; valid while `ready`=1.
- `overflow`  input  1  FIFO overflow indication from ps2_keyboard.
- `ovf_clr`  input  1  clears `ovf_sticky`.
- `nextdata_n`  output  1  active-low pop strobe to the FIFO; registered.
- `key_code`  output  8  scan code of the currently held key.
- `key_ext`  output  1  held key carried the E0 prefix.
- `key_valid`  output  1  a key is currently held.
- `press_cnt`  output  PRESS_W  count of distinct key presses.
- `make_pulse`  output  1  one-cycle strobe on a new press.
- `break_pulse`  output  1  one-cycle strobe on release of the held key.
- `ovf_sticky`  output  1  latched overflow.

Behaviour:
- Reset (`rst`=1 at an edge), values visible the next cycle:
  - state=IDLE, `nextdata_n`=1.
  - `key_code`=0, `key_ext`=0, `key_valid`=0, `press_cnt`=0.
  - Both pulses 0, `ovf_sticky`=0.
  - Prefix flags `ext_pend`=0 and `brk_pend`=0; timeout counter cleared.
  - A reset during POP/RECOV abandons the pop. The byte already consumed is lost; this is acceptable.
- FSM states: IDLE, POP, RECOV.
  - IDLE, `ready`=0: stay in IDLE.
  - IDLE, `ready`=1 in cycle N: decode `data` at the edge ending N, go to POP.
  - POP (cycle N+1): `nextdata_n`=0; go to RECOV.
  - RECOV (cycle N+2): `nextdata_n`=1, `ready` ignored; go to IDLE.
  - The earliest next byte is accepted at N+3, giving a throughput of 1 byte per 3 cycles.
  - `nextdata_n` is low for exactly one cycle per byte and never low outside POP.
- Decode of byte B, with results visible in cycle N+1 (latency 1); the pulses are high only during N+1:
  - B=E0: set `ext_pend`; no other change.
  - B=F0: set `brk_pend`; no other change.
  - Repeated prefixes keep their flags set; prefix order (E0 F0 or F0 E0) is irrelevant.
  - B=E1: consumed and ignored; flags unchanged.
  - Other B with `brk_pend`=1 (break):
    - If `key_valid`=1, B==`key_code` and `ext_pend`==`key_ext`: clear `key_valid` and fire `break_pulse`.
    - Otherwise: no output change.
    - In both cases `key_code`/`key_ext` are retained and both flags are cleared.
  - Other B with `brk_pend`=0 (make):
    - If `key_valid`=1, B==`key_code` and `ext_pend`==`key_ext`: typematic repeat; no output change.
    - Otherwise: `key_code`=B, `key_ext`=`ext_pend`, `key_valid`=1, `press_cnt`+=1 (wrapping), fire `make_pulse`.
    - Both flags are cleared.
- Timeout:
  - The counter increments each cycle while in IDLE with `ready`=0 and (`ext_pend` | `brk_pend`).
  - It resets to 0 on any accepted byte or when no flag is set.
  - When it reaches TIMEOUT-1, both flags clear on the next edge.
- Overflow:
  - `ovf_sticky` is set when `overflow`=1 and cleared when `ovf_clr`=1.
  - If both are asserted in the same cycle, set wins.
  - Independent of FSM state.

Test Plan:
- Reset, then FIFO supplies 1C:
  - `make_pulse` is high 1 cycle after `ready` is sampled, with `key_code`=1C, `key_valid`=1, `press_cnt`=1.
  - `nextdata_n`=0 for exactly one cycle.
- Stream 1C,1C,1C (typematic) then F0,1C:
  - `press_cnt` stays 1.
  - `break_pulse` fires once, then `key_valid`=0 with `key_code`=1C retained.
- E0,75 then F0,75 (non-extended break): `key_valid` stays 1, no `break_pulse`. Then E0,F0,75: `break_pulse` fires and `key_valid`=0.
- F0 alone with TIMEOUT=16:
  - Wait 20 idle cycles, then send 32: it is treated as a make (`key_code`=32, `press_cnt` increments).
  - Repeat with a 10-cycle gap: 32 is treated as a break instead.
- `press_cnt` wrap: 256 distinct make/break pairs return `press_cnt` to 0. `ready` held high continuously produces `nextdata_n` low once every 3 cycles.
- Overflow:
  - `overflow`=1 for 1 cycle latches `ovf_sticky`.
  - `ovf_clr` and `overflow` asserted together keep it set; `ovf_clr` alone clears it.
  - `rst` asserted mid-POP forces `nextdata_n`=1 and all outputs to 0 the next cycle.
